// File: rtl/mul113_pkg.sv
// Shared constants and types for the quotient-times-113 reconstruction block.
// Optional remainder range check is enabled with macro RECON_CHECK_EN.
package mul113_pkg;

  localparam int DIVISOR = 113;

  localparam int QW_DEF = 56;
  localparam int CW_DEF = 7;
  localparam int XW_DEF = 60;

  localparam int NCHUNK = QW_DEF / CW_DEF;

  localparam int ACC_W = 64;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } state_t;

endpackage

// File: rtl/mul113_chunk.sv
// Combinational CW-bit chunk times 113 using shift-add only.
// 113 = 64 + 32 + 16 + 1.
module mul113_chunk
  import mul113_pkg::*;
#(
  parameter int CW = CW_DEF
) (
  input  logic [CW-1:0] c,
  output logic [CW+6:0] p
);

  logic [CW+6:0] c_ext;

  assign c_ext = {7'd0, c};

  assign p = (c_ext << 6)
           + (c_ext << 5)
           + (c_ext << 4)
           + c_ext;

endmodule

// File: rtl/mul113_recon.sv
// Reconstructs x = q*113 + r, one CW-bit quotient chunk per cycle.
// Define RECON_CHECK_EN to latch err = (r >= 113) at accept.
module mul113_recon
  import mul113_pkg::*;
#(
  parameter int QW = QW_DEF,
  parameter int CW = CW_DEF,
  parameter int XW = XW_DEF
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [QW-1:0] q,
  input  logic [6:0]    r,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [XW-1:0] x,
  output logic          ovf,
  output logic          err
);

  localparam int NCH = QW / CW;
  localparam int KW  = (NCH > 1) ? $clog2(NCH) : 1;

  state_t           state_q, state_d;
  logic [KW-1:0]    k_q, k_d;
  logic [QW-1:0]    q_q, q_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic [CW+6:0]    prod;
  logic             last;
  logic             accept;

  // q_q shifts right each cycle so the active chunk is always at the bottom.
  mul113_chunk #(
    .CW (CW)
  ) u_chunk (
    .c (q_q[CW-1:0]),
    .p (prod)
  );

  assign last   = (k_q == KW'(NCH - 1));
  assign accept = in_valid && (state_q == IDLE);

  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    q_d     = q_q;
    acc_d   = acc_q;
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          q_d     = q;
          acc_d   = ACC_W'(r);
          k_d     = '0;
          state_d = BUSY;
        end
      end
      BUSY: begin
        acc_d = acc_q
              + (ACC_W'(prod) << (k_q * CW));
        q_d   = q_q >> CW;
        k_d   = k_q + 1'b1;
        if (last) begin
          state_d = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      k_q     <= '0;
      q_q     <= '0;
      acc_q   <= '0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      q_q     <= q_d;
      acc_q   <= acc_d;
    end
  end

`ifdef RECON_CHECK_EN
  logic err_q, err_d;

  always_comb begin
    err_d = err_q;
    if (accept) begin
      err_d = (r >= 7'(DIVISOR));
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_d;
    end
  end

  assign err = err_q;
`else
  logic unused_accept;

  assign unused_accept = accept;
  assign err = 1'b0;
`endif

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);

  // Partial sums are hidden until the result is complete.
  assign x   = out_valid ? acc_q[XW-1:0] : '0;
  assign ovf = out_valid && (|acc_q[ACC_W-1:XW]);

endmodule

// File: tb/tb_mul113_recon.sv
// Self-checking bench for mul113_recon against an arithmetic model.
// Build with RECON_CHECK_EN defined to also exercise the err flag.
module tb_mul113_recon;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [55:0] q;
  logic [6:0]  r;
  logic        out_valid;
  logic        out_ready;
  logic [59:0] x;
  logic        ovf;
  logic        err;

  int compared;
  int mismatched;

  mul113_recon dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .q         (q),
    .r         (r),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .x         (x),
    .ovf       (ovf),
    .err       (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [63:0] full_val(
    input logic [55:0] qv,
    input logic [6:0]  rv
  );
    return 64'(qv) * 64'd113 + 64'(rv);
  endfunction

  function automatic logic [59:0] ref_x(
    input logic [55:0] qv,
    input logic [6:0]  rv
  );
    logic [63:0] f;
    f = full_val(qv, rv);
    return f[59:0];
  endfunction

  function automatic logic ref_ovf(
    input logic [55:0] qv,
    input logic [6:0]  rv
  );
    return full_val(qv, rv) >= (64'd1 << 60);
  endfunction

  function automatic logic ref_err(input logic [6:0] rv);
`ifdef RECON_CHECK_EN
    return rv >= 7'd113;
`else
    return 1'b0;
`endif
  endfunction

  task automatic start_op(
    input logic [55:0] qv,
    input logic [6:0]  rv
  );
    in_valid = 1'b1;
    q        = qv;
    r        = rv;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    q        = {$urandom, $urandom};
    r        = 7'($urandom);
  endtask

  task automatic wait_done(output int lat);
    lat = 0;
    while (out_valid !== 1'b1 && lat < 20) begin
      @(posedge clk);
      #1;
      lat++;
    end
    if (out_valid !== 1'b1) lat = -1;
  endtask

  task automatic consume();
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    q         = '0;
    r         = '0;
    repeat (3) @(posedge clk);
    #1;
    compared++;
    if (out_valid !== 1'b0 || x !== 60'd0 ||
        ovf !== 1'b0 || err !== 1'b0) begin
      mismatched++;
      $display("FAIL reset_outputs: got ov=%b x=%0d ovf=%b err=%b want 0/0/0/0",
               out_valid, x, ovf, err);
    end
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    compared++;
    if (in_ready !== 1'b1) begin
      mismatched++;
      $display("FAIL reset_in_ready: got %b want 1", in_ready);
    end
  endtask

  task automatic test_directed();
    logic [55:0] qs [5];
    logic [6:0]  rs [5];
    int          n;
    int          lat;
    qs[0] = 56'd0;                 rs[0] = 7'd0;
    qs[1] = 56'd1;                 rs[1] = 7'd112;
    qs[2] = (56'd1 << 53) - 56'd1; rs[2] = 7'd112;
    qs[3] = 56'd1 << 54;           rs[3] = 7'd0;
    qs[4] = 56'd12345;             rs[4] = 7'd113;
`ifdef RECON_CHECK_EN
    n = 5;
`else
    n = 4;
`endif
    for (int i = 0; i < n; i++) begin
      start_op(qs[i], rs[i]);
      wait_done(lat);
      compared++;
      if (lat !== 8) begin
        mismatched++;
        $display("FAIL dir%0d_latency: got %0d want 8", i, lat);
      end
      compared++;
      if (x !== ref_x(qs[i], rs[i])) begin
        mismatched++;
        $display("FAIL dir%0d_x: got %0d want %0d",
                 i, x, ref_x(qs[i], rs[i]));
      end
      compared++;
      if (ovf !== ref_ovf(qs[i], rs[i])) begin
        mismatched++;
        $display("FAIL dir%0d_ovf: got %b want %b",
                 i, ovf, ref_ovf(qs[i], rs[i]));
      end
      compared++;
      if (err !== ref_err(rs[i])) begin
        mismatched++;
        $display("FAIL dir%0d_err: got %b want %b",
                 i, err, ref_err(rs[i]));
      end
      consume();
      compared++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
        mismatched++;
        $display("FAIL dir%0d_release: got rdy=%b ov=%b want 1/0",
                 i, in_ready, out_valid);
      end
    end
    compared++;
    if (ref_x(qs[2], rs[2]) !== 60'd1017813515785732095 ||
        ref_x(qs[3], rs[3]) !== 60'd49 << 54) begin
      mismatched++;
      $display("FAIL model_anchor: got %0d/%0d want fixed values",
               ref_x(qs[2], rs[2]), ref_x(qs[3], rs[3]));
    end
  endtask

  task automatic test_stall();
    logic [55:0] qv;
    logic [6:0]  rv;
    logic [59:0] x0;
    int          lat;
    bit          bad;
    qv = {$urandom, $urandom};
    rv = 7'($urandom_range(0, 112));
    start_op(qv, rv);
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1;
      q        = {$urandom, $urandom};
      r        = 7'($urandom_range(0, 112));
      @(posedge clk);
      #1;
      in_valid = 1'b0;
    end
    wait_done(lat);
    compared++;
    if (lat + 3 !== 8) begin
      mismatched++;
      $display("FAIL stall_latency: got %0d want 8", lat + 3);
    end
    x0  = x;
    bad = 1'b0;
    in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      if (x !== x0 || in_ready !== 1'b0 || out_valid !== 1'b1)
        bad = 1'b1;
    end
    in_valid = 1'b0;
    compared++;
    if (bad) begin
      mismatched++;
      $display("FAIL stall_hold: got x=%0d rdy=%b ov=%b want x=%0d 0/1",
               x, in_ready, out_valid, x0);
    end
    compared++;
    if (x !== ref_x(qv, rv) || ovf !== ref_ovf(qv, rv)) begin
      mismatched++;
      $display("FAIL stall_result: got %0d/%b want %0d/%b",
               x, ovf, ref_x(qv, rv), ref_ovf(qv, rv));
    end
    consume();
  endtask

  task automatic test_reset_abort();
    logic [55:0] qv;
    logic [6:0]  rv;
    int          lat;
    bit          seen;
    start_op(56'hAB_CDEF_0123_4567, 7'd50);
    repeat (3) begin
      @(posedge clk);
      #1;
    end
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    compared++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || x !== 60'd0) begin
      mismatched++;
      $display("FAIL abort_state: got rdy=%b ov=%b x=%0d want 1/0/0",
               in_ready, out_valid, x);
    end
    seen = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk);
      #1;
      if (out_valid === 1'b1) seen = 1'b1;
    end
    compared++;
    if (seen) begin
      mismatched++;
      $display("FAIL abort_no_output: got out_valid=1 want 0");
    end
    qv = {$urandom, $urandom};
    rv = 7'($urandom_range(0, 112));
    start_op(qv, rv);
    wait_done(lat);
    compared++;
    if (lat !== 8 || x !== ref_x(qv, rv) || ovf !== ref_ovf(qv, rv)) begin
      mismatched++;
      $display("FAIL abort_recover: got lat=%0d x=%0d ovf=%b want 8/%0d/%b",
               lat, x, ovf, ref_x(qv, rv), ref_ovf(qv, rv));
    end
    consume();
  endtask

  task automatic test_random();
    logic [55:0] qv;
    logic [6:0]  rv;
    int          lat;
    for (int i = 0; i < 40; i++) begin
      qv = {$urandom, $urandom};
      if (i % 4 == 0) qv = qv >> $urandom_range(0, 40);
`ifdef RECON_CHECK_EN
      rv = 7'($urandom_range(0, 127));
`else
      rv = 7'($urandom_range(0, 112));
`endif
      start_op(qv, rv);
      wait_done(lat);
      compared++;
      if (lat !== 8 || x !== ref_x(qv, rv) ||
          ovf !== ref_ovf(qv, rv) || err !== ref_err(rv)) begin
        mismatched++;
        $display("FAIL rand%0d: q=%0d r=%0d got lat=%0d x=%0d ovf=%b err=%b want 8/%0d/%b/%b",
                 i, qv, rv, lat, x, ovf, err,
                 ref_x(qv, rv), ref_ovf(qv, rv), ref_err(rv));
      end
      repeat ($urandom_range(0, 3)) begin
        @(posedge clk);
        #1;
      end
      consume();
    end
  endtask

  task automatic test_back_to_back();
    logic [55:0] qv;
    logic [6:0]  rv;
    int          lat;
    for (int i = 0; i < 3; i++) begin
      qv = {$urandom, $urandom};
      rv = 7'($urandom_range(0, 112));
      start_op(qv, rv);
      wait_done(lat);
      compared++;
      if (lat !== 8 || x !== ref_x(qv, rv) || ovf !== ref_ovf(qv, rv)) begin
        mismatched++;
        $display("FAIL b2b%0d: got lat=%0d x=%0d ovf=%b want 8/%0d/%b",
                 i, lat, x, ovf, ref_x(qv, rv), ref_ovf(qv, rv));
      end
      consume();
    end
  endtask

  initial begin
    compared   = 0;
    mismatched = 0;
    test_reset();
    test_directed();
    test_stall();
    test_reset_abort();
    test_random();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             compared, mismatched);
    $finish;
  end

endmodule

// File: doc/mul113_recon.md
MUL113_RECON -- requirements
Module: mul113_recon

Interface
REQ-001 Parameter QW, 56, quotient width in bits; SHALL be a multiple of CW.
REQ-002 Parameter CW, 7, quotient chunk width consumed per iteration.
REQ-003 Parameter XW, 60, reconstructed dividend width.
REQ-004 Port clk  in  1  single clock; all state updates on rising edge.
REQ-005 Port rst_n  in  1  synchronous, active-low reset.
REQ-006 Port in_valid  in  1  q/r operands valid.
REQ-007 Port in_ready  out  1  block can accept operands.
REQ-008 Port q  in  QW  quotient (unsigned).
REQ-009 Port r  in  7  remainder (unsigned, legal range 0..112).
REQ-010 Port out_valid  out  1  result valid.
REQ-011 Port out_ready  in  1  consumer accepts result.
REQ-012 Port x  out  XW  reconstructed value, low XW bits of q*113+r.
REQ-013 Port ovf  out  1  true result is at least 2^XW.
REQ-014 Port err  out  1  r >= 113 (only with RECON_CHECK_EN).

Function
REQ-015 Function: x SHALL equal (q*113 + r) mod 2^XW; this is the inverse of the divide-by-113 quotient LUT stages.
REQ-016 FSM states: IDLE, BUSY, DONE; in_ready=1 only in IDLE; out_valid=1 only in DONE.
REQ-017 IDLE: on in_valid&in_ready, latch q, load accumulator (64 bits) with zero-extended r, chunk index k=0, go to BUSY.
REQ-018 BUSY: each cycle, acc += (q[k*CW +: CW] * 113) << (k*CW); k++; after k=QW/CW-1 (8th chunk), go to DONE.
REQ-019 Latency: out_valid SHALL rise exactly QW/CW (8) clock edges after the accepting edge.
REQ-020 DONE: x, ovf, err held stable while out_valid=1 and out_ready=0; on out_ready=1, go to IDLE the next edge.
REQ-021 in_ready is low in DONE, so no accept can coincide with output consumption; minimum interval between accepts is 10 cycles.
REQ-022 ovf = OR of acc[63:XW] at DONE; the accumulator SHALL NOT wrap below 64 bits.
REQ-023 in_valid in BUSY/DONE SHALL be ignored; q/r changes after acceptance SHALL NOT affect the result.
REQ-024 Chunk multiply by 113 SHALL be shift-add ((c<<6)+(c<<5)+(c<<4)+c); no generic multiplier.

Reset
REQ-025 rst_n=0 at any edge: state=IDLE, k=0, acc=0, out_valid=0, x=0, ovf=0, err=0; in_ready=1 on the first cycle after release.
REQ-026 Reset in BUSY or DONE SHALL abort the operation; the result is never presented.

Configuration
REQ-027 Macro RECON_CHECK_EN defined: err latched at accept as (r >= 113) and held through DONE; the computation proceeds unchanged.
REQ-028 RECON_CHECK_EN undefined: err tied 0, no comparator logic.

Structure
REQ-029 Shared package mul113_pkg holds the constant DIVISOR=113, QW/CW/XW defaults, the chunk count, and the state enum type.
REQ-030 One sub-module, mul113_chunk (combinational CW-bit times 113 shift-add), instantiated once in the datapath.

Verification
REQ-031 q=0, r=0 -> x=0, ovf=0, out_valid exactly 8 cycles after accept.
REQ-032 q=1, r=112 -> x=225, ovf=0, err=0.
REQ-033 q=2^53-1, r=112 -> x=1017813515785732095, ovf=0.
REQ-034 q=2^54, r=0 -> ovf=1, x=49*2^54.
REQ-035 out_ready held low 5 cycles in DONE -> x stable, in_ready=0 throughout; in_valid pulses during BUSY are ignored.
REQ-036 rst_n low at BUSY cycle 4 -> out_valid never asserts; a new accept then yields the correct result. With RECON_CHECK_EN, r=113 gives err=1 and x=q*113+113.
